// File: rtl/sent_tx_channel_v2.sv
// Single-channel SENT (SAE J2716) transmitter with double-buffered configuration,
// up to MAX_NIBBLES data nibbles, and none/fixed/variable pause modes.
module sent_tx_channel_v2 #(
    parameter int CLK_FREQ    = 100000000,
    parameter int MAX_NIBBLES = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sent_en,
    input  logic                     cfg_valid,
    input  logic [7:0]               cfg_ctick_len,
    input  logic [7:0]               cfg_ltick_len,
    input  logic [1:0]               cfg_pause_mode,
    input  logic [15:0]              cfg_pause_len,
    input  logic                     cfg_crc_mode,
    input  logic [3:0]               cfg_status_nibble,
    input  logic [3:0]               cfg_data_len,
    input  logic [4*MAX_NIBBLES-1:0] cfg_data_nibble,
    output logic                     sent,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     cfg_err,
    output logic [15:0]              frame_cnt
);
    localparam int CLK_PER_US = CLK_FREQ / 1000000;
    localparam int TW         = $clog2(90 * CLK_PER_US + 1);
    localparam int DW         = 4 * MAX_NIBBLES;

    typedef struct packed {
        logic [7:0]    ctick;
        logic [7:0]    ltick;
        logic [1:0]    pmode;
        logic [15:0]   plen;
        logic          crc_mode;
        logic [3:0]    status;
        logic [3:0]    dlen;
        logic [DW-1:0] data;
    } cfg_t;

    typedef enum logic [2:0] {IDLE, START, SYNC, STATUS, DATA, CRC, PAUSE} state_t;

    state_t        state;
    cfg_t          pend, act, in_cfg, ld_cfg;
    logic          pend_vld, act_vld, in_ok;
    logic [TW-1:0] tick_cyc, cyc_cnt;
    logic [15:0]   tick_cnt, pulse_len, pause_ticks;
    logic [3:0]    nib_idx, crc;
    logic [10:0]   frame_ticks;
    logic          tick_end, pulse_end, last_pulse;

    function automatic logic [3:0] nib_at(input logic [DW-1:0] d, input logic [3:0] i);
        logic [DW-1:0] s;
        s = d << (4 * i);
        return s[DW-1 -: 4];
    endfunction

    function automatic logic [3:0] crc_of(input cfg_t c);
        logic [3:0] r;
        logic       fb;
        r = 4'h5;
        for (int k = 0; k < MAX_NIBBLES; k++) begin
            if (k < int'(c.dlen)) begin
                for (int b = 3; b >= 0; b--) begin
                    fb = r[3] ^ c.data[4*(MAX_NIBBLES-1-k)+b];
                    r  = {r[2:0], 1'b0} ^ (fb ? 4'hD : 4'h0);
                end
            end
        end
        // recommended mode appends one zero nibble
        if (c.crc_mode) begin
            for (int b = 0; b < 4; b++) begin
                fb = r[3];
                r  = {r[2:0], 1'b0} ^ (fb ? 4'hD : 4'h0);
            end
        end
        return r;
    endfunction

    function automatic logic [10:0] sum_of(input cfg_t c);
        logic [10:0] s;
        s = '0;
        for (int k = 0; k < MAX_NIBBLES; k++)
            if (k < int'(c.dlen)) s = s + 11'(nib_at(c.data, 4'(k)));
        return s;
    endfunction

    assign in_cfg = {cfg_ctick_len, cfg_ltick_len, cfg_pause_mode, cfg_pause_len, cfg_crc_mode,
                     cfg_status_nibble, cfg_data_len, cfg_data_nibble};

    always_comb begin
        in_ok = (cfg_ctick_len >= 8'd3) && (cfg_ctick_len <= 8'd90) &&
                (cfg_ltick_len >= 8'd4) && (cfg_ltick_len <= 8'd11) &&
                (cfg_pause_mode != 2'd3) &&
                ((cfg_pause_mode == 2'd0) || ((cfg_pause_len >= 16'd12) && (cfg_pause_len <= 16'd768))) &&
                (cfg_data_len >= 4'd1) && (cfg_data_len <= 4'(MAX_NIBBLES));
        // a legal strobe on a boundary edge goes straight into the next frame
        ld_cfg = (cfg_valid && in_ok) ? in_cfg : (pend_vld ? pend : act);
    end

    always_comb begin
        crc         = crc_of(act);
        frame_ticks = 11'd56 + 11'd12 * (11'(act.dlen) + 11'd2) + 11'(act.status) + sum_of(act) + 11'(crc);
        pause_ticks = act.plen;
        if (act.pmode == 2'd2) begin
            if ({5'd0, frame_ticks} + 16'd12 > act.plen) pause_ticks = 16'd12;
            else                                         pause_ticks = act.plen - {5'd0, frame_ticks};
        end
        tick_end   = (cyc_cnt == tick_cyc - TW'(1));
        pulse_end  = tick_end && (tick_cnt == pulse_len - 16'd1);
        last_pulse = (state == PAUSE) || ((state == CRC) && (act.pmode == 2'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pend       <= '0;
            act        <= '0;
            pend_vld   <= 1'b0;
            act_vld    <= 1'b0;
            tick_cyc   <= '0;
            cyc_cnt    <= '0;
            tick_cnt   <= '0;
            pulse_len  <= '0;
            nib_idx    <= '0;
            sent       <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            cfg_err    <= cfg_valid && !in_ok;
            if (cfg_valid && in_ok) begin
                pend     <= in_cfg;
                pend_vld <= 1'b1;
            end
            case (state)
                IDLE: begin
                    sent <= 1'b1;
                    busy <= 1'b0;
                    if (sent_en && (pend_vld || act_vld)) begin
                        act      <= ld_cfg;
                        act_vld  <= 1'b1;
                        pend_vld <= 1'b0;
                        tick_cyc <= TW'(ld_cfg.ctick * CLK_PER_US);
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    state     <= SYNC;
                    sent      <= 1'b0;
                    cyc_cnt   <= '0;
                    tick_cnt  <= '0;
                    pulse_len <= 16'd56;
                end
                default: begin
                    if (!tick_end) begin
                        cyc_cnt <= cyc_cnt + TW'(1);
                    end else if (!pulse_end) begin
                        cyc_cnt  <= '0;
                        tick_cnt <= tick_cnt + 16'd1;
                        sent     <= (tick_cnt + 16'd1 >= {8'd0, act.ltick});
                    end else begin
                        cyc_cnt  <= '0;
                        tick_cnt <= '0;
                        sent     <= 1'b0;
                        if (last_pulse) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            act        <= ld_cfg;
                            pend_vld   <= 1'b0;
                            tick_cyc   <= TW'(ld_cfg.ctick * CLK_PER_US);
                            if (sent_en) begin
                                state     <= SYNC;
                                pulse_len <= 16'd56;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                sent  <= 1'b1;
                            end
                        end else begin
                            case (state)
                                SYNC: begin
                                    state     <= STATUS;
                                    pulse_len <= 16'd12 + 16'(act.status);
                                end
                                STATUS: begin
                                    state     <= DATA;
                                    nib_idx   <= '0;
                                    pulse_len <= 16'd12 + 16'(nib_at(act.data, 4'd0));
                                end
                                DATA: begin
                                    if (nib_idx == act.dlen - 4'd1) begin
                                        state     <= CRC;
                                        pulse_len <= 16'd12 + 16'(crc);
                                    end else begin
                                        nib_idx   <= nib_idx + 4'd1;
                                        pulse_len <= 16'd12 + 16'(nib_at(act.data, nib_idx + 4'd1));
                                    end
                                end
                                CRC: begin
                                    state     <= PAUSE;
                                    pulse_len <= pause_ticks;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sent_tx_channel_v2.sv
// Bench for sent_tx_channel_v2: measures every pulse on the line and compares it
// against a frame model built from tick counts and a polynomial-division CRC.
module tb_sent_tx_channel_v2;
    localparam int CLK_FREQ = 2000000;
    localparam int MAXN     = 6;
    localparam int CPU      = CLK_FREQ / 1000000;

    logic        clk = 0, rst = 1, sent_en = 0, cfg_valid = 0;
    logic [7:0]  cfg_ctick_len = 0, cfg_ltick_len = 0;
    logic [1:0]  cfg_pause_mode = 0;
    logic [15:0] cfg_pause_len = 0;
    logic        cfg_crc_mode = 0;
    logic [3:0]  cfg_status_nibble = 0, cfg_data_len = 0;
    logic [23:0] cfg_data_nibble = 0;
    logic        sent, busy, frame_done, cfg_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    sent_tx_channel_v2 #(.CLK_FREQ(CLK_FREQ), .MAX_NIBBLES(MAXN)) dut (
        .clk(clk), .rst(rst), .sent_en(sent_en), .cfg_valid(cfg_valid),
        .cfg_ctick_len(cfg_ctick_len), .cfg_ltick_len(cfg_ltick_len),
        .cfg_pause_mode(cfg_pause_mode), .cfg_pause_len(cfg_pause_len),
        .cfg_crc_mode(cfg_crc_mode), .cfg_status_nibble(cfg_status_nibble),
        .cfg_data_len(cfg_data_len), .cfg_data_nibble(cfg_data_nibble),
        .sent(sent), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
        .frame_cnt(frame_cnt)
    );

    typedef struct {
        int ctick; int ltick; int pmode; int plen; int crcm; int status; int dlen;
        logic [23:0] data;
    } cfg_s;
    typedef struct { cfg_s c; int exp_crc; int exp_pause; } vec_t;

    int errors = 0, checks = 0, exp_frames = 0;
    int q_len[$], q_low[$], exp_q[$];

    // line monitor: one record per pulse (falling edge to next falling edge or frame end)
    int   cur_len = 0, cur_low = 0;
    bit   open_p = 0;
    logic prev_sent = 1;
    always @(negedge clk) begin
        if (rst) begin
            open_p = 0; prev_sent = 1;
        end else begin
            if (open_p && (frame_done || (prev_sent && !sent))) begin
                q_len.push_back(cur_len); q_low.push_back(cur_low); open_p = 0;
            end
            if (prev_sent && !sent) begin open_p = 1; cur_len = 0; cur_low = 0; end
            if (open_p) begin cur_len++; if (!sent) cur_low++; end
            prev_sent = sent;
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic cfg_s mk(int ct, int lt, int pm, int pl, int cm, int st, int dl, logic [23:0] d);
        cfg_s c;
        c.ctick = ct; c.ltick = lt; c.pmode = pm; c.plen = pl;
        c.crcm = cm; c.status = st; c.dlen = dl; c.data = d;
        return c;
    endfunction

    function automatic int nib(cfg_s c, int k);
        logic [23:0] s;
        s = c.data >> (4 * (MAXN - 1 - k));
        return int'(s[3:0]);
    endfunction

    // CRC as the remainder of (seed*x^n + M*x^4) mod (x^4+x^3+x^2+1)
    function automatic int model_crc(cfg_s c);
        longint v, msg;
        int n;
        msg = 0; n = 0;
        for (int k = 0; k < c.dlen; k++) begin msg = (msg << 4) | longint'(nib(c, k)); n += 4; end
        if (c.crcm != 0) begin msg = msg << 4; n += 4; end
        v = (longint'(5) << n) ^ (msg << 4);
        for (int b = 63; b >= 4; b--) if (v[b]) v = v ^ (longint'(29) << (b - 4));
        return int'(v & 15);
    endfunction

    task automatic build_exp(input cfg_s c);
        int sum;
        exp_q.delete();
        exp_q.push_back(56);
        exp_q.push_back(12 + c.status);
        for (int k = 0; k < c.dlen; k++) exp_q.push_back(12 + nib(c, k));
        exp_q.push_back(12 + model_crc(c));
        sum = 0;
        foreach (exp_q[i]) sum += exp_q[i];
        if (c.pmode == 1) exp_q.push_back(c.plen);
        else if (c.pmode == 2) exp_q.push_back((c.plen - sum < 12) ? 12 : c.plen - sum);
    endtask

    task automatic check_pulses(input string name, input cfg_s c, input int base);
        int t;
        t = c.ctick * CPU;
        build_exp(c);
        chk({name, "_npulses"}, q_len.size() >= base + exp_q.size(), 1);
        if (q_len.size() < base + exp_q.size()) return;
        foreach (exp_q[i]) begin
            chk($sformatf("%s_p%0d_len", name, i), q_len[base+i], exp_q[i] * t);
            chk($sformatf("%s_p%0d_low", name, i), q_low[base+i], c.ltick * t);
        end
    endtask

    task automatic drive(input cfg_s c);
        cfg_ctick_len = 8'(c.ctick); cfg_ltick_len = 8'(c.ltick);
        cfg_pause_mode = 2'(c.pmode); cfg_pause_len = 16'(c.plen);
        cfg_crc_mode = c.crcm[0]; cfg_status_nibble = 4'(c.status);
        cfg_data_len = 4'(c.dlen); cfg_data_nibble = c.data;
        cfg_valid = 1;
    endtask

    task automatic wait_fd(input string name, input int maxc);
        int n;
        n = 0;
        while (!frame_done && n < maxc) begin @(negedge clk); n++; end
        chk({name, "_frame_done"}, frame_done, 1);
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!busy && n < 5) begin @(negedge clk); n++; end
        chk({name, "_start"}, busy, 1);
    endtask

    task automatic run_one(input string name, input cfg_s c, input bit lat);
        q_len.delete(); q_low.delete();
        @(negedge clk); drive(c); sent_en = 1;
        @(negedge clk); cfg_valid = 0;
        if (lat) begin
            chk({name, "_lat_busy1"}, busy, 0);
            @(negedge clk);
            chk({name, "_lat_busy2"}, busy, 1);
            chk({name, "_lat_sent2"}, sent, 1);
            @(negedge clk);
            chk({name, "_lat_sent3"}, sent, 0);
        end else begin
            wait_busy(name);
        end
        sent_en = 0;
        wait_fd(name, 20000);
        exp_frames++;
        chk({name, "_frame_cnt"}, frame_cnt, exp_frames);
        @(negedge clk);
        chk({name, "_done_1cyc"}, frame_done, 0);
        check_pulses(name, c, 0);
        repeat (3) @(negedge clk);
        chk({name, "_idle_sent"}, sent, 1);
        chk({name, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        vec_t vecs[5];
        cfg_s ill[7];
        cfg_s c1, cF, c7, c3, rc;
        int   t, l2;

        c1 = mk(3, 4, 0, 0, 0, 'hA, 1, 24'h000000);
        // hand-derived expectations: crc nibble and pause ticks
        vecs[0] = '{c: c1,                                          exp_crc: 3,   exp_pause: 0};
        vecs[1] = '{c: mk(3, 4, 0, 0, 1, 'hA, 1, 24'h000000),       exp_crc: 'hA, exp_pause: 0};
        vecs[2] = '{c: mk(3, 4, 2, 200, 0, 'hA, 1, 24'h000000),     exp_crc: 3,   exp_pause: 95};
        vecs[3] = '{c: mk(3, 4, 2, 100, 0, 'hA, 1, 24'h000000),     exp_crc: 3,   exp_pause: 12};
        vecs[4] = '{c: mk(4, 11, 1, 20, 0, 0, 6, 24'h123456),       exp_crc: -1,  exp_pause: 20};

        ill[0] = mk(2, 4, 0, 0, 0, 'hA, 1, 0);
        ill[1] = mk(3, 3, 0, 0, 0, 'hA, 1, 0);
        ill[2] = mk(3, 4, 0, 0, 0, 'hA, 0, 0);
        ill[3] = mk(3, 4, 0, 0, 0, 'hA, 7, 0);
        ill[4] = mk(3, 4, 3, 100, 0, 'hA, 1, 0);
        ill[5] = mk(3, 4, 1, 11, 0, 'hA, 1, 0);
        ill[6] = mk(91, 4, 0, 0, 0, 'hA, 1, 0);

        repeat (2) @(negedge clk);
        chk("rst_sent", sent, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_cnt", frame_cnt, 0);
        rst = 0;

        // illegal configs with sent_en high: nothing may start
        sent_en = 1;
        foreach (ill[i]) begin
            @(negedge clk); drive(ill[i]);
            @(negedge clk); cfg_valid = 0;
            chk($sformatf("ill%0d_err", i), cfg_err, 1);
            @(negedge clk);
            chk($sformatf("ill%0d_err_once", i), cfg_err, 0);
            repeat (3) @(negedge clk);
            chk($sformatf("ill%0d_sent", i), sent, 1);
            chk($sformatf("ill%0d_busy", i), busy, 0);
        end
        sent_en = 0;

        foreach (vecs[i]) begin
            run_one($sformatf("vec%0d", i), vecs[i].c, i == 0);
            t = vecs[i].c.ctick * CPU;
            if (vecs[i].exp_crc >= 0)
                chk($sformatf("vec%0d_crc", i), q_len[2 + vecs[i].c.dlen], (12 + vecs[i].exp_crc) * t);
            if (vecs[i].exp_pause > 0)
                chk($sformatf("vec%0d_pause", i), q_len[3 + vecs[i].c.dlen], vecs[i].exp_pause * t);
        end

        for (int i = 0; i < 6; i++) begin
            rc.ctick  = int'($urandom_range(4, 3));
            rc.ltick  = int'($urandom_range(11, 4));
            rc.pmode  = int'($urandom_range(2, 0));
            rc.plen   = (rc.pmode == 1) ? int'($urandom_range(80, 12)) :
                        (rc.pmode == 2) ? int'($urandom_range(300, 12)) : int'($urandom_range(65535, 0));
            rc.crcm   = int'($urandom_range(1, 0));
            rc.status = int'($urandom_range(15, 0));
            rc.dlen   = int'($urandom_range(MAXN, 1));
            rc.data   = 24'($urandom);
            run_one($sformatf("rnd%0d", i), rc, 0);
        end

        // config updates mid-frame and in the very last cycle of a frame
        cF = mk(3, 4, 0, 0, 0, 'hA, 1, 24'hF00000);
        c7 = mk(3, 4, 0, 0, 0, 'hA, 1, 24'h700000);
        c3 = mk(3, 4, 0, 0, 0, 'hA, 1, 24'h300000);
        t  = 3 * CPU;
        q_len.delete(); q_low.delete();
        @(negedge clk); drive(c1); sent_en = 1;
        @(negedge clk); cfg_valid = 0;
        wait_busy("upd");
        repeat (20) @(negedge clk);
        drive(cF); @(negedge clk); cfg_valid = 0;
        repeat (5) @(negedge clk);
        drive(c7); @(negedge clk); cfg_valid = 0;
        wait_fd("upd_f1", 20000);
        exp_frames++;
        build_exp(c7);
        l2 = 0;
        foreach (exp_q[i]) l2 += exp_q[i] * t;
        repeat (l2 - 1) @(negedge clk);
        drive(c3);
        @(negedge clk); cfg_valid = 0;
        chk("upd_f2_boundary", frame_done, 1);
        exp_frames++;
        sent_en = 0;
        @(negedge clk);
        wait_fd("upd_f3", 20000);
        exp_frames++;
        chk("upd_frame_cnt", frame_cnt, exp_frames);
        @(negedge clk);
        check_pulses("upd_f1", c1, 0);
        check_pulses("upd_f2", c7, 4);
        check_pulses("upd_f3", c3, 8);
        chk("upd_f1_data", q_len[2], 12 * t);
        chk("upd_f2_data", q_len[6], 19 * t);
        chk("upd_f3_data", q_len[10], 15 * t);
        repeat (3) @(negedge clk);
        chk("upd_idle_sent", sent, 1);

        // asynchronous reset in the low phase of a DATA pulse
        @(negedge clk); drive(c1); sent_en = 1;
        @(negedge clk); cfg_valid = 0;
        wait_busy("rstm");
        repeat ((56 + 22 + 3) * t) @(negedge clk);
        chk("rstm_pre_low", sent, 0);
        #2 rst = 1;
        #1;
        chk("rstm_sent", sent, 1);
        chk("rstm_busy", busy, 0);
        chk("rstm_cnt", frame_cnt, 0);
        @(negedge clk); rst = 0;
        exp_frames = 0;
        repeat (20) @(negedge clk);
        chk("rstm_stay_idle", busy, 0);
        chk("rstm_stay_high", sent, 1);
        sent_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
